dmem_access_master: RTL

- Initiator-side load/store sequencer that drives the single-port word Data_memory interface: address, write data, write strobe, read strobe in; read data back.
- Accepts byte, halfword and word requests from the core over a valid/ready handshake.
- Drives word-aligned memory cycles; sub-word stores use read-modify-write.
- Memory is byte-addressed, big-endian: the byte at the word address occupies bits [31:24].

---
 rtl/dmem_access_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dmem_access_master.sv
// Load/store sequencer for a single-port, word-wide, big-endian data memory.
// Sub-word stores are performed as a read-modify-write of the containing word.
module dmem_access_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE = 2'b00, RD = 2'b01, WR = 2'b10, RESP = 2'b11} state_t;

   state_t      state_r;
   logic        write_r;
   logic        signed_r;
   logic [1:0]  size_r;
   logic [1:0]  lane_r;
   logic [31:0] wdata_r;
   logic        req_err_s;
   logic        accept_s;

   // Big-endian lane select: byte k sits in [31-8k -: 8], halfword by addr[1].
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'b00:   b = word[31:24];
         2'b01:   b = word[23:16];
         2'b10:   b = word[15:8];
         default: b = word[7:0];
      endcase
      h = lane[1] ? word[15:0] : word[31:16];
      case (size)
         2'b00:   r = {{24{sgn & b[7]}}, b};
         2'b01:   r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic [31:0] wdata);
      logic [31:0] r;
      r = word;
      case (size)
         2'b00: begin
            case (lane)
               2'b00:   r[31:24] = wdata[7:0];
               2'b01:   r[23:16] = wdata[7:0];
               2'b10:   r[15:8]  = wdata[7:0];
               default: r[7:0]   = wdata[7:0];
            endcase
         end
         2'b01: begin
            if (lane[1]) r[15:0] = wdata[15:0];
            else         r[31:16] = wdata[15:0];
         end
         default: r = wdata;
      endcase
      return r;
   endfunction

   // Misaligned or illegal-size request detection.
   always_comb begin
      req_err_s = 1'b0;
      case (req_size)
         2'b00:   req_err_s = 1'b0;
         2'b01:   req_err_s = req_addr[0];
         2'b10:   req_err_s = (req_addr[1:0] != 2'b00);
         default: req_err_s = 1'b1;
      endcase
   end

   assign req_ready = rst_n & (state_r == IDLE);
   assign accept_s  = req_valid & req_ready;

   // Sequencer: request capture, memory cycles and one-cycle response pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         write_r    <= 1'b0;
         signed_r   <= 1'b0;
         size_r     <= 2'b00;
         lane_r     <= 2'b00;
         wdata_r    <= 32'h0000_0000;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= 32'h0000_0000;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  write_r  <= req_write;
                  signed_r <= req_signed;
                  size_r   <= req_size;
                  lane_r   <= req_addr[1:0];
                  wdata_r  <= req_wdata;
                  if (req_err_s) begin
                     state_r    <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0000_0000;
                  end else begin
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     if (req_write && (req_size == 2'b10)) begin
                        state_r   <= WR;
                        mem_write <= 1'b1;
                        mem_wdata <= req_wdata;
                     end else begin
                        state_r  <= RD;
                        mem_read <= 1'b1;
                     end
                  end
               end
            end
            RD: begin
               mem_read <= 1'b0;
               if (write_r) begin
                  state_r   <= WR;
                  mem_write <= 1'b1;
                  mem_wdata <= store_merge(mem_rdata, size_r, lane_r, wdata_r);
               end else begin
                  state_r    <= RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= load_extract(mem_rdata, size_r, lane_r, signed_r);
               end
            end
            WR: begin
               mem_write  <= 1'b0;
               mem_wdata  <= 32'h0000_0000;
               state_r    <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0000_0000;
            end
            RESP: begin
               resp_valid <= 1'b0;
               resp_rdata <= 32'h0000_0000;
               resp_err   <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               state_r   <= IDLE;
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               mem_wdata <= 32'h0000_0000;
            end
         endcase
      end
   end

endmodule
